cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_types.sv | 29 ++
 rtl/cache_perf_counter.sv | 25 ++
 rtl/cache_control.sv | 141 ++++++++++++++
 tb/tb_cache_control.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// Shared cache typedefs: way indexing, per-way masks, controller states and mux encodings.
package cache_types;

  localparam int unsigned NUM_WAYS = 2;

  typedef logic [NUM_WAYS-1:0] way_mask_t;
  typedef logic                way_idx_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } cache_state_e;

  typedef enum logic {
    SRC_CPU  = 1'b0,
    SRC_PMEM = 1'b1
  } data_src_e;

  typedef enum logic {
    ADDR_CPU    = 1'b0,
    ADDR_VICTIM = 1'b1
  } pmem_addr_e;

  function automatic way_mask_t way_onehot(way_idx_t w);
    return w ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_perf_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones once full.
module cache_perf_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && !(&count_q)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_control.sv
// Two-way cache controller: hit handling, dirty-victim writeback and line fill.
// Optional hit/miss performance counters are built when CACHE_PERF_COUNTERS_EN is defined.
//
// state     | meaning
// IDLE      | serve hits; on a miss latch the LRU way as victim
// WRITEBACK | write the dirty victim line back to physical memory
// FETCH     | read the requested line and fill it into the victim way
module cache_control
  import cache_types::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  input  logic [1:0] hit,
  input  logic [1:0] dirty,
  input  logic       lru,
  output logic [1:0] load_data,
  output logic [1:0] load_tag,
  output logic [1:0] load_valid,
  output logic [1:0] load_dirty,
  output logic       dirty_in,
  output logic       load_lru,
  output logic       lru_in,
  output logic       way_sel,
  output logic       data_src_sel,
  output logic       pmem_addr_sel
`ifdef CACHE_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
`endif
);

  cache_state_e state_q, state_d;
  way_idx_t     victim_q, victim_d;

  logic     req;
  logic     hit_any;
  way_idx_t hit_way;

  assign req     = mem_read | mem_write;
  assign hit_any = |hit;
  // Way 0 wins if both ways claim a hit.
  assign hit_way = ~hit[0];

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    load_data     = '0;
    load_tag      = '0;
    load_valid    = '0;
    load_dirty    = '0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    way_sel       = 1'b0;
    data_src_sel  = SRC_CPU;
    pmem_addr_sel = ADDR_CPU;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit_any) begin
            mem_resp = 1'b1;
            way_sel  = hit_way;
            load_lru = 1'b1;
            lru_in   = ~hit_way;
            if (mem_write) begin
              load_data  = way_onehot(hit_way);
              load_dirty = way_onehot(hit_way);
              dirty_in   = 1'b1;
            end
          end else begin
            victim_d = lru;
            state_d  = dirty[lru] ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = ADDR_VICTIM;
        way_sel       = victim_q;
        if (pmem_resp) state_d = FETCH;
      end
      FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data    = way_onehot(victim_q);
          load_tag     = way_onehot(victim_q);
          load_valid   = way_onehot(victim_q);
          load_dirty   = way_onehot(victim_q);
          data_src_sel = SRC_PMEM;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

`ifdef CACHE_PERF_COUNTERS_EN
  logic hit_evt, miss_evt;

  assign hit_evt  = (state_q == IDLE) && req && hit_any;
  assign miss_evt = (state_q == IDLE) && req && !hit_any;

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (hit_evt),
    .count_o (hit_count)
  );

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .en_i    (miss_evt),
    .count_o (miss_count)
  );
`endif

endmodule

// File: tb/tb_cache_control.sv
// Testbench for cache_control: directed vector table, reset corner, counter saturation, random vs model.
module tb_cache_control;

  localparam int CW = 4;

  logic       clk;
  logic       rst;
  logic       mem_read, mem_write, mem_resp;
  logic       pmem_read, pmem_write, pmem_resp;
  logic [1:0] hit, dirty;
  logic       lru;
  logic [1:0] load_data, load_tag, load_valid, load_dirty;
  logic       dirty_in, load_lru, lru_in, way_sel, data_src_sel, pmem_addr_sel;
`ifdef CACHE_PERF_COUNTERS_EN
  logic [CW-1:0] hit_count, miss_count;
`endif

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_resp      (mem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_resp     (pmem_resp),
    .hit           (hit),
    .dirty         (dirty),
    .lru           (lru),
    .load_data     (load_data),
    .load_tag      (load_tag),
    .load_valid    (load_valid),
    .load_dirty    (load_dirty),
    .dirty_in      (dirty_in),
    .load_lru      (load_lru),
    .lru_in        (lru_in),
    .way_sel       (way_sel),
    .data_src_sel  (data_src_sel),
    .pmem_addr_sel (pmem_addr_sel)
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       resp, prd, pwr, wsel, src, asel, llru, lrui, din;
    logic [1:0] ldata, ltag, lvalid, ldirty;
  } out_t;

  typedef struct {
    string      name;
    bit         rd, wr;
    logic [1:0] h, d;
    bit         l, p;
    out_t       exp;
  } vec_t;

  vec_t tv[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // reference model: 0 = serving hits, 1 = writing victim back, 2 = filling victim
  int phase = 0;
  int mv    = 0;
  int mh    = 0;
  int mm    = 0;

  task automatic add(string nm, bit rd, bit wr, logic [1:0] h, logic [1:0] d, bit l, bit p, out_t e);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.h = h; v.d = d; v.l = l; v.p = p; v.exp = e;
    tv.push_back(v);
  endtask

  task automatic drive(bit r, bit rd, bit wr, logic [1:0] h, logic [1:0] d, bit l, bit p);
    rst = r; mem_read = rd; mem_write = wr; hit = h; dirty = d; lru = l; pmem_resp = p;
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.resp = mem_resp;     o.prd = pmem_read;   o.pwr = pmem_write;
    o.wsel = way_sel;      o.src = data_src_sel; o.asel = pmem_addr_sel;
    o.llru = load_lru;     o.lrui = lru_in;      o.din = dirty_in;
    o.ldata = load_data;   o.ltag = load_tag;    o.lvalid = load_valid;
    o.ldirty = load_dirty;
    return o;
  endfunction

  task automatic check_out(string nm, out_t exp);
    out_t act;
    act = dut_out();
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

`ifdef CACHE_PERF_COUNTERS_EN
  task automatic check_cnt(string nm, int eh, int em);
    logic [CW-1:0] xh, xm;
    xh = CW'(eh > 15 ? 15 : eh);
    xm = CW'(em > 15 ? 15 : em);
    n_total++;
    if (hit_count !== xh || miss_count !== xm)
      $display("FAIL %s: got hit=%0d miss=%0d expected hit=%0d miss=%0d", nm, hit_count, miss_count, xh, xm);
    else n_pass++;
  endtask
`endif

  function automatic logic [1:0] mask(int w);
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic out_t model_out(bit rd, bit wr, logic [1:0] h, bit p);
    out_t o;
    int   w;
    o = '0;
    if (phase == 0 && (rd || wr) && h != 2'b00) begin
      w = h[0] ? 0 : 1;
      o.resp = 1'b1; o.wsel = (w == 1); o.llru = 1'b1; o.lrui = (w == 0);
      if (wr) begin
        o.ldata = mask(w); o.ldirty = mask(w); o.din = 1'b1;
      end
    end else if (phase == 1) begin
      o.pwr = 1'b1; o.asel = 1'b1; o.wsel = (mv == 1);
    end else if (phase == 2) begin
      o.prd = 1'b1;
      if (p) begin
        o.src = 1'b1;
        o.ldata = mask(mv); o.ltag = mask(mv); o.lvalid = mask(mv); o.ldirty = mask(mv);
      end
    end
    return o;
  endfunction

  task automatic model_step(bit r, bit rd, bit wr, logic [1:0] h, logic [1:0] d, bit l, bit p);
    if (r) begin
      phase = 0; mv = 0; mh = 0; mm = 0;
    end else if (phase == 0) begin
      if (rd || wr) begin
        if (h != 2'b00) mh++;
        else begin
          mm++;
          mv    = int'(l);
          phase = d[l] ? 1 : 2;
        end
      end
    end else if (p) begin
      phase = (phase == 1) ? 2 : 0;
    end
  endtask

  initial begin
    bit         cur_rd, cur_wr, r, p;
    logic [1:0] h, d;
    bit         l;
    out_t       e;

    // name  rd wr hit dirty lru presp  expected
    add("reset_idle",   0,0,2'b00,2'b00,0,0, '0);
    add("rd_hit_w1",    1,0,2'b10,2'b00,0,0, '{resp:1, wsel:1, llru:1, default:'0});
    add("idle_gap",     0,0,2'b00,2'b00,0,0, '0);
    add("wmiss_detect", 0,1,2'b00,2'b10,1,0, '0);
    add("wb_cycle1",    0,1,2'b00,2'b10,1,0, '{pwr:1, asel:1, wsel:1, default:'0});
    add("wb_cycle2",    0,1,2'b00,2'b10,1,0, '{pwr:1, asel:1, wsel:1, default:'0});
    add("wb_cycle3",    0,1,2'b00,2'b10,1,1, '{pwr:1, asel:1, wsel:1, default:'0});
    add("wfetch_wait",  0,1,2'b00,2'b10,1,0, '{prd:1, default:'0});
    add("wfetch_fill",  0,1,2'b00,2'b10,1,1,
        '{prd:1, src:1, ldata:2'b10, ltag:2'b10, lvalid:2'b10, ldirty:2'b10, default:'0});
    add("wretry_hit",   0,1,2'b10,2'b10,1,0,
        '{resp:1, wsel:1, llru:1, din:1, ldata:2'b10, ldirty:2'b10, default:'0});
    add("rmiss_detect", 1,0,2'b00,2'b10,0,0, '0);
    add("rfetch_wait",  1,0,2'b00,2'b10,0,0, '{prd:1, default:'0});
    add("rfetch_fill",  1,0,2'b00,2'b10,0,1,
        '{prd:1, src:1, ldata:2'b01, ltag:2'b01, lvalid:2'b01, ldirty:2'b01, default:'0});
    add("rretry_hit",   1,0,2'b01,2'b10,0,0, '{resp:1, llru:1, lrui:1, default:'0});
    add("both_hit_wr",  0,1,2'b11,2'b00,1,0,
        '{resp:1, llru:1, lrui:1, din:1, ldata:2'b01, ldirty:2'b01, default:'0});
    add("rdwr_hit_w1",  1,1,2'b10,2'b00,0,0,
        '{resp:1, wsel:1, llru:1, din:1, ldata:2'b10, ldirty:2'b10, default:'0});
    add("drop_detect",  1,0,2'b00,2'b00,1,0, '0);
    add("drop_wait",    0,0,2'b00,2'b00,1,0, '{prd:1, default:'0});
    add("drop_fill",    0,0,2'b00,2'b00,1,1,
        '{prd:1, src:1, ldata:2'b10, ltag:2'b10, lvalid:2'b10, ldirty:2'b10, default:'0});
    add("drop_no_resp", 0,0,2'b00,2'b00,1,0, '0);
    add("dmiss_w0",     1,0,2'b00,2'b01,0,0, '0);
    add("wb_v0",        1,0,2'b00,2'b01,0,1, '{pwr:1, asel:1, default:'0});
    add("fetch_v0",     1,0,2'b00,2'b01,0,1,
        '{prd:1, src:1, ldata:2'b01, ltag:2'b01, lvalid:2'b01, ldirty:2'b01, default:'0});
    add("idle_after",   0,0,2'b00,2'b00,0,0, '0);

    drive(1, 0,0,2'b00,2'b00,0,0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tv[i]) begin
      drive(0, tv[i].rd, tv[i].wr, tv[i].h, tv[i].d, tv[i].l, tv[i].p);
      #2;
      check_out(tv[i].name, tv[i].exp);
      @(posedge clk);
      #1;
    end
`ifdef CACHE_PERF_COUNTERS_EN
    check_cnt("table_counts", 5, 4);
`endif

    // reset landing in the middle of a writeback
    drive(0, 0,1,2'b00,2'b10,1,0);
    #2; check_out("rst_seq_detect", '0);
    @(posedge clk); #1;
    #2; check_out("rst_seq_wb", '{pwr:1, asel:1, wsel:1, default:'0});
    drive(1, 0,0,2'b00,2'b00,0,0);
    #1; check_out("rst_seq_wb_hold", '{pwr:1, asel:1, wsel:1, default:'0});
    @(posedge clk); #1;
    drive(0, 0,0,2'b00,2'b00,0,0);
    #2; check_out("rst_mid_wb_idle", '0);
`ifdef CACHE_PERF_COUNTERS_EN
    check_cnt("rst_mid_wb_cnt", 0, 0);
`endif
    @(posedge clk); #1;
    #2; check_out("rst_mid_wb_quiet", '0);
    @(posedge clk); #1;

`ifdef CACHE_PERF_COUNTERS_EN
    for (int k = 0; k < 20; k++) begin
      drive(0, 1,0,2'b01,2'b00,1,0);
      @(posedge clk); #1;
    end
    drive(0, 0,0,2'b00,2'b00,0,0);
    #2; check_cnt("hit_saturate", 15, 0);
    @(posedge clk); #1;
`endif

    // randomized traffic against the reference model
    drive(1, 0,0,2'b00,2'b00,0,0);
    model_step(1, 0,0,2'b00,2'b00,0,0);
    @(posedge clk); #1;
    cur_rd = 0; cur_wr = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!cur_rd && !cur_wr) begin
        if ($urandom % 3 != 0) begin
          case ($urandom % 3)
            0: begin cur_rd = 1; cur_wr = 0; end
            1: begin cur_rd = 0; cur_wr = 1; end
            default: begin cur_rd = 1; cur_wr = 1; end
          endcase
        end
      end else if ($urandom % 40 == 0) begin
        cur_rd = 0; cur_wr = 0;
      end
      h = ($urandom % 2 == 0) ? 2'b00 : 2'($urandom % 4);
      d = 2'($urandom % 4);
      l = 1'($urandom % 2);
      p = ($urandom % 3 == 0);
      r = ($urandom % 150 == 0);
      drive(r, cur_rd, cur_wr, h, d, l, p);
      #2;
      e = model_out(cur_rd, cur_wr, h, p);
      check_out("random", e);
`ifdef CACHE_PERF_COUNTERS_EN
      check_cnt("random_cnt", mh, mm);
`endif
      @(posedge clk);
      model_step(r, cur_rd, cur_wr, h, d, l, p);
      if (e.resp) begin cur_rd = 0; cur_wr = 0; end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
